// File: rtl/timetag_pattern_gen.sv
// rtl/timetag_pattern_gen.sv - multi-channel periodic strobe/toggle stimulus generator with event counter
// Optional per-channel LFSR period jitter is built when PATGEN_JITTER_EN is defined.
module timetag_pattern_gen #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter int EVT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_wr,
  input  logic [7:0]       cfg_addr,
  input  logic [31:0]      cfg_data,
  input  logic             run,
  output logic [N_CH-1:0]  pat_out,
  output logic [EVT_W-1:0] event_count,
  output logic             active
);

  logic             run_q;
  logic             start;
  logic             ld_all;
  logic             evt_clr;
  logic [N_CH-1:0]  sh_en, sh_mode, sh_jit;
  logic [N_CH-1:0]  ac_en, ac_mode;
  logic [CNT_W-1:0] sh_per [N_CH];
  logic [CNT_W-1:0] sh_wid [N_CH];
  logic [CNT_W-1:0] sh_ph  [N_CH];
  logic [CNT_W-1:0] ac_per [N_CH];
  logic [CNT_W-1:0] ac_wid [N_CH];
  logic [CNT_W-1:0] cnt    [N_CH];
  logic [CNT_W-1:0] ph_cnt [N_CH];
  logic [CNT_W-1:0] nxt_cnt [N_CH];
  logic [CNT_W-1:0] nxt_ph  [N_CH];
  logic [N_CH-1:0]  nxt_out, wrap, wr_sel;
  logic [4:0]       rises;
  logic [EVT_W+4:0] evt_sum;
  logic             cfg_unused;

`ifdef PATGEN_JITTER_EN
  logic [N_CH-1:0]  ac_jit;
  logic [1:0]       jit_cnt [N_CH];
  logic [1:0]       nxt_jit [N_CH];
  logic [15:0]      lfsr;
`endif

  // Upper data bits are don't-care for counter fields; the jitter bit is only stored in the plain build.
  assign cfg_unused = ^{cfg_data, sh_jit};

  assign start   = run & ~run_q;
  assign ld_all  = ~run | start;
  assign evt_clr = cfg_wr & (cfg_addr == 8'hFF);

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      wr_sel[i]  = cfg_wr & (cfg_addr[7:2] == 6'(i));
      nxt_out[i] = 1'b0;
      nxt_cnt[i] = '0;
      nxt_ph[i]  = '0;
      wrap[i]    = 1'b0;
`ifdef PATGEN_JITTER_EN
      nxt_jit[i] = '0;
`endif
      if (!run) begin
        nxt_out[i] = 1'b0;
      end else if (start) begin
        if (sh_en[i]) nxt_ph[i] = sh_ph[i];
      end else if (ac_en[i]) begin
        if (ph_cnt[i] != '0) begin
          nxt_ph[i] = ph_cnt[i] - CNT_W'(1);
`ifdef PATGEN_JITTER_EN
        end else if (jit_cnt[i] != 2'd0) begin
          // Inserted gap: pulse output stays low, toggle output holds its level.
          nxt_jit[i] = jit_cnt[i] - 2'd1;
          nxt_out[i] = ac_mode[i] & pat_out[i];
`endif
        end else if (ac_per[i] == '0) begin
          wrap[i] = 1'b1;
        end else begin
          wrap[i]    = (cnt[i] == ac_per[i] - CNT_W'(1));
          nxt_cnt[i] = wrap[i] ? '0 : cnt[i] + CNT_W'(1);
          if (ac_mode[i]) nxt_out[i] = (cnt[i] == '0) ? ~pat_out[i] : pat_out[i];
          else            nxt_out[i] = (cnt[i] < ac_wid[i]);
`ifdef PATGEN_JITTER_EN
          if (wrap[i] && ac_jit[i]) nxt_jit[i] = lfsr[1:0];
`endif
        end
      end
    end
  end

  always_comb begin
    rises = '0;
    for (int i = 0; i < N_CH; i++) rises = rises + 5'(nxt_out[i] & ~pat_out[i]);
    evt_sum = {5'b0, event_count} + {{EVT_W{1'b0}}, rises};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q       <= 1'b0;
      pat_out     <= '0;
      event_count <= '0;
      active      <= 1'b0;
      sh_en       <= '0;
      sh_mode     <= '0;
      sh_jit      <= '0;
      ac_en       <= '0;
      ac_mode     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        sh_per[i] <= '0;
        sh_wid[i] <= '0;
        sh_ph[i]  <= '0;
        ac_per[i] <= '0;
        ac_wid[i] <= '0;
        cnt[i]    <= '0;
        ph_cnt[i] <= '0;
      end
    end else begin
      run_q   <= run;
      pat_out <= nxt_out;
      active  <= run & (start ? |sh_en : |ac_en);
      if (evt_clr)                          event_count <= '0;
      else if (|evt_sum[EVT_W+4:EVT_W])     event_count <= '1;
      else                                  event_count <= evt_sum[EVT_W-1:0];
      if (ld_all) begin
        ac_en   <= sh_en;
        ac_mode <= sh_mode;
      end
      for (int i = 0; i < N_CH; i++) begin
        cnt[i]    <= nxt_cnt[i];
        ph_cnt[i] <= nxt_ph[i];
        // Period/width move to the working copy only between periods so a running period never glitches.
        if (ld_all || wrap[i]) begin
          ac_per[i] <= sh_per[i];
          ac_wid[i] <= sh_wid[i];
        end
        if (wr_sel[i]) begin
          case (cfg_addr[1:0])
            2'd0:    sh_per[i] <= cfg_data[CNT_W-1:0];
            2'd1:    sh_wid[i] <= cfg_data[CNT_W-1:0];
            2'd2:    sh_ph[i]  <= cfg_data[CNT_W-1:0];
            default: {sh_jit[i], sh_mode[i], sh_en[i]} <= cfg_data[2:0];
          endcase
        end
      end
    end
  end

`ifdef PATGEN_JITTER_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr   <= 16'hACE1;
      ac_jit <= '0;
      for (int i = 0; i < N_CH; i++) jit_cnt[i] <= '0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (ld_all) ac_jit <= sh_jit;
      for (int i = 0; i < N_CH; i++) jit_cnt[i] <= nxt_jit[i];
    end
  end
`endif

endmodule

// File: doc/timetag_pattern_gen.md
Name: timetag_pattern_gen

Overview:
Synthesisable, parametrised multi-channel stimulus generator for on-FPGA self-test of the timetagger input path.
Produces programmable periodic strobe pulses or delta-style square levels per channel, with per-channel period, width and phase offset. Keeps a running count of emitted events.
Sits in front of the strobe/delta input muxes. Configured through the register-write interface driven by the command decoder.

Parameters:
N_CH, 4, number of output channels (1..16)
CNT_W, 16, width of period/width/phase counters
EVT_W, 32, width of emitted-event counter

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
cfg_wr  input  1  register write strobe, one cycle
cfg_addr  input  8  [7:2] channel index, [1:0] field; 8'hFF = clear event counter
cfg_data  input  32  write data; [CNT_W-1:0] used for counter fields
run  input  1  level; generators active while high
pat_out  output  N_CH  per-channel pattern output, registered
event_count  output  EVT_W  total rising edges emitted on pat_out, saturating
active  output  1  high while run is sampled high and at least one channel is enabled

Behaviour:
- Reset: pat_out=0, event_count=0, active=0. All period/width/phase=0. All ctrl=0.
- Fields per channel: 0=period, 1=width, 2=phase, 3=ctrl.
  - ctrl[0]=enable.
  - ctrl[1]=mode: 0=pulse, 1=toggle.
  - ctrl[2]=jitter (feature only).
- Writes to channel index >= N_CH are ignored. Addr 8'hFF clears event_count on the next edge.
- Shadow/active registers: each channel holds shadow and active copies of period/width.
  - Writes always update the shadow copy.
  - Shadow is copied to active when run is low, and at each period wrap while running.
  - The current period always completes with the old values.
- Phase and ctrl take effect immediately when run is low. Writes to them while run is high are held in shadow until run next rises.
- Start: the first edge sampling run=1 after run=0 loads phase_cnt=phase and cnt=0.
  - An enabled channel decrements phase_cnt to 0 (out low), then counts cnt 0..period-1, wrapping.
  - Phase=P: pat_out rises P+1 cycles after the start edge.
- Pulse mode: pat_out = (cnt < width).
  - width=0: always low.
  - width >= period: constantly high; counts one event only.
- Toggle mode: pat_out inverts at every cnt==0 (square wave, half-period = period).
- period=0 holds the channel low; no events.
- Disabled channel: output low, counters held at 0.
- Stop: the first edge sampling run=0 forces all pat_out=0 and cnt=phase_cnt=0 on that same edge. Falling edges from this are not events.
- Reset mid-run: immediate return to reset values. Asynchronous assert; release takes effect on the next clk edge.
- event_count: each cycle adds the number of channels whose pat_out rises (popcount, 0..N_CH). Saturates at 2^EVT_W-1.
  - Clear and a simultaneous rise in the same cycle: clear wins, result 0.
- active is registered, with the same timing as the start/stop edges.

Optional Feature:
PATGEN_JITTER_EN
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every cycle.
  - On each period wrap of a channel with ctrl[2]=1, lfsr[1:0] (0..3) extra low cycles are inserted before cnt restarts.
  - In pulse mode the extra cycles are low. In toggle mode they hold the level.
- Undefined: ctrl[2] is stored but ignored; no LFSR logic; periods are exact.

Test Plan:
- Ch0: period=10, width=2, phase=0, pulse, enable; run high 100 cycles -> pat_out[0] high 2 of every 10 cycles, first rise 1 cycle after start; event_count=10.
- Ch1: period=7, phase=5, toggle; ch0 as above; run 70 cycles -> ch1 first edge at cycle 6, toggling every 7; event_count includes ch1 rises only on 0->1 transitions.
- Write ch0 period=4 mid-run -> current 10-cycle period completes, then 4-cycle periods; no glitch pulse.
- Boundaries: period=0 -> out low, no events. width=12 with period=10 -> constant high, event_count=1. Write to channel 5 (N_CH=4) -> no effect. event_count preloaded near max (EVT_W=4, 14) plus 3 rises -> holds 15.
- Drop run mid-pulse -> pat_out=0 on that edge, active=0, count unchanged. Assert reset_n low asynchronously mid-run -> all outputs 0 immediately.
- PATGEN_JITTER_EN: ch0 period=10, jitter=1 -> interval between rises in 10..13 and matches the LFSR model. Without the macro -> always exactly 10.
